// File: rtl/inst_prebuf_pkg.sv
// Shared constants and types for the fetch-to-decode instruction buffer:
// MIPS opcode/rt/func codes used by the branch pre-decoder and the
// per-entry pre-decode flag record.
package inst_prebuf_pkg;

    localparam int INST_W = 32;

    // primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    // REGIMM rt sub-codes
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // SPECIAL func codes
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    // j/jal keep the region bits of pc+4 above this field
    localparam logic [27:0] J_LOW_MASK = 28'hFFF_FFFF;

    // pre-decode flags stored alongside every buffered instruction
    typedef struct packed {
        logic is_branch;
        logic is_link;
        logic is_direct;
        logic in_slot;
    } predec_t;

endpackage

// File: rtl/mips_branch_predec.sv
// Combinational MIPS branch pre-decoder: classifies one instruction word as
// branch / link / direct and computes its static target (0 when indirect).
module mips_branch_predec
    import inst_prebuf_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [INST_W-1:0] inst,
    input  logic [PC_W-1:0]   pc,
    output logic              is_branch,
    output logic              is_link,
    output logic              is_direct,
    output logic [PC_W-1:0]   target
);

    logic [5:0]        op;
    logic [5:0]        fn;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sa;
    logic              is_jump;
    logic signed [17:0] br_off;
    logic [PC_W-1:0]   pc4;
    logic [PC_W-1:0]   br_tgt;
    logic [PC_W-1:0]   j_tgt;

    assign op = inst[31:26];
    assign rt = inst[20:16];
    assign rd = inst[15:11];
    assign sa = inst[10:6];
    assign fn = inst[5:0];

    assign pc4    = pc + PC_W'(4);
    assign br_off = {inst[15:0], 2'b00};
    // sign-extending cast; overflow past PC_W wraps silently
    assign br_tgt = pc4 + PC_W'(br_off);
    assign j_tgt  = (pc4 & ~PC_W'(J_LOW_MASK)) | PC_W'({inst[25:0], 2'b00});

    // classify the word; anything not matched exactly is a plain instruction
    always_comb begin
        is_branch = 1'b0;
        is_link   = 1'b0;
        is_direct = 1'b0;
        is_jump   = 1'b0;
        case (op)
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                is_direct = 1'b1;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ) begin
                    is_branch = 1'b1;
                    is_direct = 1'b1;
                end else if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
                    is_branch = 1'b1;
                    is_direct = 1'b1;
                    is_link   = 1'b1;
                end
            end
            OP_BLEZ, OP_BGTZ: begin
                if (rt == 5'd0) begin
                    is_branch = 1'b1;
                    is_direct = 1'b1;
                end
            end
            OP_J, OP_JAL: begin
                is_branch = 1'b1;
                is_direct = 1'b1;
                is_jump   = 1'b1;
                is_link   = (op == OP_JAL);
            end
            OP_SPECIAL: begin
                if (fn == FN_JR && rt == 5'd0 && rd == 5'd0 && sa == 5'd0) begin
                    is_branch = 1'b1;
                end else if (fn == FN_JALR && rt == 5'd0 && sa == 5'd0) begin
                    is_branch = 1'b1;
                    is_link   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // static target select; register-indirect branches report 0
    always_comb begin
        target = '0;
        if (is_direct) target = is_jump ? j_tgt : br_tgt;
    end

endmodule

// File: rtl/inst_prebuf.sv
// Fetch-to-decode instruction buffer with per-entry branch pre-decode and
// delay-slot tagging. Circular buffer of DEPTH entries; ds_* come from the
// head entry register.
// Optional feature: define PREDEC_BYPASS_EN to let an empty buffer forward
// the offered fetch word (and its pre-decode) to ID in the same cycle.
module inst_prebuf
    import inst_prebuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    fs_valid,
    input  logic [PC_W-1:0]         fs_pc,
    input  logic [INST_W-1:0]       fs_inst,
    output logic                    fs_ready,
    input  logic                    ds_allowin,
    output logic                    ds_valid,
    output logic [PC_W-1:0]         ds_pc,
    output logic [INST_W-1:0]       ds_inst,
    output logic                    ds_is_branch,
    output logic                    ds_is_link,
    output logic                    ds_is_direct,
    output logic [PC_W-1:0]         ds_target,
    output logic                    ds_in_slot,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   tgt_mem  [DEPTH];
    predec_t           flag_mem [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              slot_pend;

    logic              pd_branch;
    logic              pd_link;
    logic              pd_direct;
    logic [PC_W-1:0]   pd_target;
    predec_t           pd_flags;

    logic              push;
    logic              pop;
    logic              push_wr;
    logic              pop_buf;

    mips_branch_predec #(.PC_W(PC_W)) u_predec (
        .inst      (fs_inst),
        .pc        (fs_pc),
        .is_branch (pd_branch),
        .is_link   (pd_link),
        .is_direct (pd_direct),
        .target    (pd_target)
    );

    assign pd_flags = '{is_branch: pd_branch, is_link: pd_link,
                        is_direct: pd_direct, in_slot: slot_pend};

    // flush keeps IF unblocked so the redirect fetch is never back-pressured
    assign fs_ready = (count != FULL) | flush;
    assign push     = fs_valid & fs_ready & ~flush;
    assign pop      = ds_valid & ds_allowin & ~flush;

`ifdef PREDEC_BYPASS_EN
    logic byp;
    // an empty buffer hands the fetch word straight to ID
    assign byp     = (count == '0) & ~flush & fs_valid;
    assign push_wr = push & ~(byp & ds_allowin);
    assign pop_buf = pop & ~byp;
`else
    assign push_wr = push;
    assign pop_buf = pop;
`endif

    // entry storage: written at the tail on an accepted, non-consumed push
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                tgt_mem[i]  <= '0;
                flag_mem[i] <= '0;
            end
        end else if (push_wr) begin
            pc_mem[wr_ptr]   <= fs_pc;
            inst_mem[wr_ptr] <= fs_inst;
            tgt_mem[wr_ptr]  <= pd_target;
            flag_mem[wr_ptr] <= pd_flags;
        end
    end

    // pointers, occupancy and delay-slot tracker
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            slot_pend <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            slot_pend <= 1'b0;
        end else begin
            if (push_wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop_buf) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_wr) - CW'(pop_buf);
            // a bypassed word still occupies the delay-slot sequence
            if (push) slot_pend <= pd_branch;
        end
    end

    // head view presented to ID
    always_comb begin
        ds_valid     = (count != '0);
        ds_pc        = pc_mem[rd_ptr];
        ds_inst      = inst_mem[rd_ptr];
        ds_target    = tgt_mem[rd_ptr];
        ds_is_branch = flag_mem[rd_ptr].is_branch;
        ds_is_link   = flag_mem[rd_ptr].is_link;
        ds_is_direct = flag_mem[rd_ptr].is_direct;
        ds_in_slot   = flag_mem[rd_ptr].in_slot;
`ifdef PREDEC_BYPASS_EN
        if (byp) begin
            ds_valid     = 1'b1;
            ds_pc        = fs_pc;
            ds_inst      = fs_inst;
            ds_target    = pd_target;
            ds_is_branch = pd_branch;
            ds_is_link   = pd_link;
            ds_is_direct = pd_direct;
            ds_in_slot   = slot_pend;
        end
`endif
    end

endmodule

// File: tb/tb_inst_prebuf.sv
// Self-checking bench for inst_prebuf: directed scenarios plus a random run,
// all compared against a queue-based reference model.
module tb_inst_prebuf;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   flush;
    logic                   fs_valid;
    logic [PC_W-1:0]        fs_pc;
    logic [31:0]            fs_inst;
    logic                   fs_ready;
    logic                   ds_allowin;
    logic                   ds_valid;
    logic [PC_W-1:0]        ds_pc;
    logic [31:0]            ds_inst;
    logic                   ds_is_branch;
    logic                   ds_is_link;
    logic                   ds_is_direct;
    logic [PC_W-1:0]        ds_target;
    logic                   ds_in_slot;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        slot;
    } ent_t;

    ent_t q[$];
    logic m_slot;

    inst_prebuf #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_ready(fs_ready),
        .ds_allowin(ds_allowin), .ds_valid(ds_valid), .ds_pc(ds_pc), .ds_inst(ds_inst),
        .ds_is_branch(ds_is_branch), .ds_is_link(ds_is_link), .ds_is_direct(ds_is_direct),
        .ds_target(ds_target), .ds_in_slot(ds_in_slot), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // reference classification written straight from the MIPS encoding rules
    function automatic void ref_dec(input logic [31:0] i, input logic [31:0] pc,
                                    output logic br, output logic lk,
                                    output logic dir, output logic [31:0] tgt);
        int op  = int'(i[31:26]);
        int rt  = int'(i[20:16]);
        int rd  = int'(i[15:11]);
        int sa  = int'(i[10:6]);
        int fn  = int'(i[5:0]);
        logic [31:0] pc4 = pc + 32'd4;
        logic jmp = 1'b0;
        br = 0; lk = 0; dir = 0; tgt = 0;
        if (op == 4 || op == 5) begin br = 1; dir = 1; end
        if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) begin
            br = 1; dir = 1; lk = (rt >= 16);
        end
        if ((op == 6 || op == 7) && rt == 0) begin br = 1; dir = 1; end
        if (op == 2 || op == 3) begin br = 1; dir = 1; jmp = 1; lk = (op == 3); end
        if (op == 0 && fn == 8 && rt == 0 && rd == 0 && sa == 0) br = 1;
        if (op == 0 && fn == 9 && rt == 0 && sa == 0) begin br = 1; lk = 1; end
        if (dir) begin
            if (jmp) tgt = (pc4 & 32'hF000_0000) + {4'h0, i[25:0], 2'b00};
            else     tgt = pc4 + 32'($signed(i[15:0]) * 4);
        end
    endfunction

    function automatic logic ref_br(input logic [31:0] i);
        logic br, lk, dir;
        logic [31:0] t;
        ref_dec(i, 32'h0, br, lk, dir, t);
        return br;
    endfunction

    // one clock: compare DUT against model before the edge, then advance model
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic allow, input logic fl);
        ent_t e;
        logic have, br, lk, dir;
        logic [31:0] tgt;
        logic empty, full;
        fs_valid = v; fs_pc = pc; fs_inst = inst; ds_allowin = allow; flush = fl;
        @(negedge clk);
        empty = (q.size() == 0);
        full  = (q.size() == DEPTH);
        chk("count", 64'(count), 64'(q.size()));
        chk("fs_ready", 64'(fs_ready), 64'(!full || fl));
        have = !empty;
        if (have) e = q[0];
`ifdef PREDEC_BYPASS_EN
        if (empty && v && !fl) begin
            have = 1'b1;
            e = '{pc: pc, inst: inst, slot: m_slot};
        end
`endif
        chk("ds_valid", 64'(ds_valid), 64'(have));
        if (have) begin
            ref_dec(e.inst, e.pc, br, lk, dir, tgt);
            chk("ds_pc", 64'(ds_pc), 64'(e.pc));
            chk("ds_inst", 64'(ds_inst), 64'(e.inst));
            chk("ds_is_branch", 64'(ds_is_branch), 64'(br));
            chk("ds_is_link", 64'(ds_is_link), 64'(lk));
            chk("ds_is_direct", 64'(ds_is_direct), 64'(dir));
            chk("ds_target", 64'(ds_target), 64'(tgt));
            chk("ds_in_slot", 64'(ds_in_slot), 64'(e.slot));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            m_slot = 1'b0;
        end else begin
`ifdef PREDEC_BYPASS_EN
            if (empty && v && allow) begin
                m_slot = ref_br(inst);
            end else
`endif
            begin
                if (allow && !empty) void'(q.pop_front());
                if (v && !full) begin
                    q.push_back('{pc: pc, inst: inst, slot: m_slot});
                    m_slot = ref_br(inst);
                end
            end
        end
    endtask

    task automatic idle(input logic allow);
        cycle(1'b0, 32'h0, 32'h0, allow, 1'b0);
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] w = $urandom;
        logic [4:0] rts [5] = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h03};
        case ($urandom_range(0, 9))
            0: w[31:26] = 6'h04;
            1: w[31:26] = 6'h05;
            2: begin w[31:26] = 6'h01; w[20:16] = rts[$urandom_range(0, 4)]; end
            3: begin w[31:26] = 6'($urandom_range(6, 7)); if ($urandom_range(0, 3) != 0) w[20:16] = 5'h0; end
            4: w[31:26] = 6'($urandom_range(2, 3));
            5: begin w = {6'h0, w[25:21], 15'h0, 6'h08}; if ($urandom_range(0, 3) == 0) w[15:11] = 5'h3; end
            6: begin w = {6'h0, w[25:21], 5'h0, w[15:11], 5'h0, 6'h09}; end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] r;
        resetn = 1'b0; flush = 1'b0; fs_valid = 1'b0; fs_pc = '0; fs_inst = '0; ds_allowin = 1'b0;
        m_slot = 1'b0;
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ds_valid", 64'(ds_valid), 64'd0);
        chk("rst_fs_ready", 64'(fs_ready), 64'd1);
        chk("rst_ds_data", {ds_pc, ds_inst}, 64'd0);
        chk("rst_ds_target", 64'(ds_target), 64'd0);
        chk("rst_ds_flags", 64'({ds_is_branch, ds_is_link, ds_is_direct, ds_in_slot}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // fill past capacity, then drain in order
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 32'h2400_0000 + 32'(i), 1'b0, 1'b0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ready", 64'(fs_ready), 64'd0);
        cycle(1'b1, 32'h200, 32'h2400_0055, 1'b1, 1'b0);   // full: pop only
        chk("full_pushpop_count", 64'(count), 64'd3);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drain_count", 64'(count), 64'd0);

        // beq and delay-slot tagging
        cycle(1'b1, 32'hBFC0_0010, 32'h1000_FFFF, 1'b0, 1'b0);
        chk("beq_branch", 64'(ds_is_branch), 64'd1);
        chk("beq_direct", 64'(ds_is_direct), 64'd1);
        chk("beq_target", 64'(ds_target), 64'hBFC0_0010);
        cycle(1'b1, 32'hBFC0_0014, 32'h0000_0000, 1'b1, 1'b0);
        chk("slot_after_beq", 64'(ds_in_slot), 64'd1);
        cycle(1'b1, 32'hBFC0_0018, 32'h0000_0000, 1'b1, 1'b0);
        chk("slot_cleared", 64'(ds_in_slot), 64'd0);
        idle(1'b1);

        // jal / jalr / jr with rd!=0
        cycle(1'b1, 32'hBFC0_0000, 32'h0C00_0100, 1'b0, 1'b0);
        chk("jal_link", 64'(ds_is_link), 64'd1);
        chk("jal_target", 64'(ds_target), 64'hB000_0400);
        idle(1'b1);
        cycle(1'b1, 32'hBFC0_0004, 32'h0040_F809, 1'b0, 1'b0);
        chk("jalr_flags", 64'({ds_is_branch, ds_is_link, ds_is_direct}), 64'b110);
        chk("jalr_target", 64'(ds_target), 64'd0);
        idle(1'b1);
        cycle(1'b1, 32'hBFC0_0008, 32'h0040_0808, 1'b0, 1'b0);
        chk("jr_rd_branch", 64'(ds_is_branch), 64'd0);
        idle(1'b1);

        // flush with count=3, slot_pend=1 and a concurrent push
        cycle(1'b1, 32'h300, 32'h2400_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h2400_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'h308, 32'h1000_0004, 1'b0, 1'b0);
        chk("preflush_count", 64'(count), 64'd3);
        cycle(1'b1, 32'h30C, 32'h2400_0003, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(ds_valid), 64'd0);
        cycle(1'b1, 32'h400, 32'h2400_0004, 1'b0, 1'b0);
        chk("post_flush_slot", 64'(ds_in_slot), 64'd0);
        idle(1'b1);

        // pointer wrap under steady push+pop at count=2
        cycle(1'b1, 32'h500, 32'h2400_0010, 1'b0, 1'b0);
        cycle(1'b1, 32'h504, 32'h2400_0011, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h508 + 32'(4 * i), 32'h2400_0020 + 32'(i), 1'b1, 1'b0);
        chk("wrap_count", 64'(count), 64'd2);
        idle(1'b1);
        idle(1'b1);

        // asynchronous reset in the middle of operation
        cycle(1'b1, 32'h600, 32'h1000_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h604, 32'h2400_0001, 1'b0, 1'b0);
        fs_valid = 1'b0; ds_allowin = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_valid", 64'(ds_valid), 64'd0);
        q.delete();
        m_slot = 1'b0;
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            r = rnd_inst();
            cycle(1'($urandom_range(0, 3) != 0), 32'($urandom) & 32'hFFFF_FFFC, r,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
